// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for the multi-cycle RV32I datapath. Define
//            PERF_CNT_EN to add cycle/retired-instruction counters.
// Revision : 1.0
// ============================================================================
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        Mem_Addr_Sel,
    output logic        MemWrite,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic [1:0]  PC_Src,
    output logic [2:0]  SE_Control,
    output logic [1:0]  ALU_SrcA,
    output logic        ALU_SrcB,
    output logic [1:0]  ALU_Op,
    output logic        RegWrite,
    output logic [1:0]  WB_Sel,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam int               c_to_w    = $clog2(TIMEOUT);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_cause;
    logic [1:0]        w_next_cause;
    logic [c_to_w-1:0] r_to_cnt;

    logic [6:0] w_opcode;
    logic w_is_r, w_is_imm, w_is_load, w_is_store, w_is_branch;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_illegal;
    logic [2:0] w_se;
    logic w_to_hit;
    logic w_unused_ir;

    assign w_opcode    = IR[6:0];
    assign w_unused_ir = ^IR[31:7];
    assign w_is_r      = (w_opcode == c_op_r);
    assign w_is_imm    = (w_opcode == c_op_imm);
    assign w_is_load   = (w_opcode == c_op_load);
    assign w_is_store  = (w_opcode == c_op_store);
    assign w_is_branch = (w_opcode == c_op_branch);
    assign w_is_jal    = (w_opcode == c_op_jal);
    assign w_is_jalr   = (w_opcode == c_op_jalr);
    assign w_is_lui    = (w_opcode == c_op_lui);
    assign w_is_auipc  = (w_opcode == c_op_auipc);
    assign w_illegal   = !(w_is_r || w_is_imm || w_is_load || w_is_store || w_is_branch ||
                           w_is_jal || w_is_jalr || w_is_lui || w_is_auipc);

    assign w_se = w_is_store               ? 3'd1 :
                  w_is_branch              ? 3'd2 :
                  (w_is_lui || w_is_auipc) ? 3'd3 :
                  w_is_jal                 ? 3'd4 : 3'd0;

    // Ready on the last allowed cycle takes priority over the timeout trap.
    assign w_to_hit = (r_to_cnt == c_to_last) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_cause  <= 2'd0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_cause <= w_next_cause;
            if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready &&
                (w_next_state == r_state))
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        mem_req      = 1'b0;
        Mem_Addr_Sel = 1'b0;
        MemWrite     = 1'b0;
        IR_Write     = 1'b0;
        PC_Write     = 1'b0;
        PC_Src       = 2'd0;
        SE_Control   = 3'd0;
        ALU_SrcA     = 2'd0;
        ALU_SrcB     = 1'b0;
        ALU_Op       = 2'd0;
        RegWrite     = 1'b0;
        WB_Sel       = 2'd0;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IR_Write     = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_to_hit) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'd2;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'd1;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                ALU_SrcB = !(w_is_r || w_is_branch);
                ALU_SrcA = (w_is_jal || w_is_auipc) ? 2'd1 :
                           w_is_lui                 ? 2'd2 : 2'd0;
                ALU_Op   = (w_is_r || w_is_imm) ? 2'd2 :
                           w_is_branch          ? 2'd1 : 2'd0;
                if (w_is_branch) begin
                    PC_Write     = 1'b1;
                    PC_Src       = branch_taken ? 2'd2 : 2'd0;
                    w_next_state = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                Mem_Addr_Sel = 1'b1;
                MemWrite     = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        PC_Write     = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else if (w_to_hit) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'd2;
                end
            end
            S_WB: begin
                RegWrite     = 1'b1;
                PC_Write     = 1'b1;
                WB_Sel       = w_is_load ? 2'd1 : (w_is_jal || w_is_jalr) ? 2'd2 : 2'd0;
                PC_Src       = (w_is_jal || w_is_jalr) ? 2'd1 : 2'd0;
                w_next_state = S_FETCH;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        if (r_state != S_FETCH && r_state != S_TRAP)
            SE_Control = w_se;

        // Reset is synchronous, so strobes must be masked combinationally while it is held.
        if (!rst_n) begin
            mem_req      = 1'b0;
            Mem_Addr_Sel = 1'b0;
            MemWrite     = 1'b0;
            IR_Write     = 1'b0;
            PC_Write     = 1'b0;
            PC_Src       = 2'd0;
            SE_Control   = 3'd0;
            ALU_SrcA     = 2'd0;
            ALU_SrcB     = 1'b0;
            ALU_Op       = 2'd0;
            RegWrite     = 1'b0;
            WB_Sel       = 2'd0;
        end
    end

    assign trap       = rst_n && (r_state == S_TRAP);
    assign trap_cause = rst_n ? r_cause : 2'd0;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_TRAP)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (PC_Write)
                r_instret_cnt <= r_instret_cnt + 1'b1;
        end
    end

    assign cycle_cnt   = rst_n ? r_cycle_cnt   : '0;
    assign instret_cnt = rst_n ? r_instret_cnt : '0;
`else
    logic [CNT_W-1:0] w_unused_cnt_w;
    assign w_unused_cnt_w = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed scoreboard bench for multicycle_control.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IR;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, Mem_Addr_Sel, MemWrite, IR_Write, PC_Write;
    logic [1:0]  PC_Src;
    logic [2:0]  SE_Control;
    logic [1:0]  ALU_SrcA;
    logic        ALU_SrcB;
    logic [1:0]  ALU_Op;
    logic        RegWrite;
    logic [1:0]  WB_Sel;
    logic        trap;
    logic [1:0]  trap_cause;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .IR(IR), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .Mem_Addr_Sel(Mem_Addr_Sel),
        .MemWrite(MemWrite), .IR_Write(IR_Write), .PC_Write(PC_Write),
        .PC_Src(PC_Src), .SE_Control(SE_Control), .ALU_SrcA(ALU_SrcA),
        .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op), .RegWrite(RegWrite),
        .WB_Sel(WB_Sel), .trap(trap), .trap_cause(trap_cause)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        logic       mem_req;
        logic       addr_sel;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [2:0] se;
        logic [1:0] src_a;
        logic       src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       trap;
        logic [1:0] cause;
    } exp_t;

    localparam logic [31:0] c_add   = 32'h002081B3;
    localparam logic [31:0] c_addi  = 32'h00100093;
    localparam logic [31:0] c_lui   = 32'h000000B7;
    localparam logic [31:0] c_auipc = 32'h00000097;
    localparam logic [31:0] c_jal   = 32'h0000006F;
    localparam logic [31:0] c_jalr  = 32'h00008067;
    localparam logic [31:0] c_lw    = 32'h0000A183;
    localparam logic [31:0] c_beq   = 32'h00208463;
    localparam logic [31:0] c_sw    = 32'h0020A023;
    localparam logic [31:0] c_ill   = 32'h0000007F;

    exp_t  q_exp[$];
    string q_name[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    exp_t  act;
    exp_t  m_exp;
    string m_name;

    assign act = {mem_req, Mem_Addr_Sel, MemWrite, IR_Write, PC_Write, PC_Src, SE_Control,
                  ALU_SrcA, ALU_SrcB, ALU_Op, RegWrite, WB_Sel, trap, trap_cause};

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
            n_checks++;
            if (act !== m_exp) begin
                n_fails++;
                $display("FAIL %s: got %h expected %h", m_name, act, m_exp);
            end
        end
    end

    function automatic exp_t e_fetch(input logic irw);
        exp_t e;
        e = '0; e.mem_req = 1'b1; e.ir_write = irw;
        return e;
    endfunction

    function automatic exp_t e_dec(input logic [2:0] se);
        exp_t e;
        e = '0; e.se = se;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic [2:0] se, input logic [1:0] sa,
                                    input logic sb, input logic [1:0] op);
        exp_t e;
        e = '0; e.se = se; e.src_a = sa; e.src_b = sb; e.alu_op = op;
        return e;
    endfunction

    function automatic exp_t e_br(input logic [1:0] pcs);
        exp_t e;
        e = '0; e.se = 3'd2; e.alu_op = 2'd1; e.pc_write = 1'b1; e.pc_src = pcs;
        return e;
    endfunction

    function automatic exp_t e_mem(input logic [2:0] se, input logic mw, input logic pcw);
        exp_t e;
        e = '0; e.se = se; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_write = mw; e.pc_write = pcw;
        return e;
    endfunction

    function automatic exp_t e_wb(input logic [2:0] se, input logic [1:0] wbs, input logic [1:0] pcs);
        exp_t e;
        e = '0; e.se = se; e.reg_write = 1'b1; e.pc_write = 1'b1; e.wb_sel = wbs; e.pc_src = pcs;
        return e;
    endfunction

    function automatic exp_t e_trap(input logic [1:0] cause);
        exp_t e;
        e = '0; e.trap = 1'b1; e.cause = cause;
        return e;
    endfunction

    task automatic cyc(input logic [31:0] ir_v, input logic bt, input logic rdy,
                       input logic rstn, input exp_t e, input string nm);
        @(posedge clk); #1;
        IR = ir_v; branch_taken = bt; mem_ready = rdy; rst_n = rstn;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic run_alu(input logic [31:0] ir_v, input logic [2:0] se, input logic [1:0] sa,
                           input logic sb, input logic [1:0] op, input logic [1:0] wbs,
                           input logic [1:0] pcs, input string nm);
        cyc(ir_v, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), {nm, " fetch"});
        cyc(ir_v, 1'b0, 1'b1, 1'b1, e_dec(se), {nm, " decode"});
        cyc(ir_v, 1'b0, 1'b1, 1'b1, e_exec(se, sa, sb, op), {nm, " exec"});
        cyc(ir_v, 1'b0, 1'b1, 1'b1, e_wb(se, wbs, pcs), {nm, " wb"});
    endtask

    initial begin
        IR = 32'h0; branch_taken = 1'b0; mem_ready = 1'b0; rst_n = 1'b0;
        cyc(c_add, 1'b0, 1'b1, 1'b0, '0, "reset");
        cyc(c_add, 1'b0, 1'b1, 1'b0, '0, "reset hold");

        run_alu(c_add,   3'd0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd0, "add");
        run_alu(c_addi,  3'd0, 2'd0, 1'b1, 2'd2, 2'd0, 2'd0, "addi");
        run_alu(c_lui,   3'd3, 2'd2, 1'b1, 2'd0, 2'd0, 2'd0, "lui");
        run_alu(c_auipc, 3'd3, 2'd1, 1'b1, 2'd0, 2'd0, 2'd0, "auipc");
        run_alu(c_jal,   3'd4, 2'd1, 1'b1, 2'd0, 2'd2, 2'd1, "jal");
        run_alu(c_jalr,  3'd0, 2'd0, 1'b1, 2'd0, 2'd2, 2'd1, "jalr");

        // Load with three wait cycles in MEM
        cyc(c_lw, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "lw fetch");
        cyc(c_lw, 1'b0, 1'b1, 1'b1, e_dec(3'd0), "lw decode");
        cyc(c_lw, 1'b0, 1'b1, 1'b1, e_exec(3'd0, 2'd0, 1'b1, 2'd0), "lw exec");
        for (int i = 0; i < 3; i++)
            cyc(c_lw, 1'b0, 1'b0, 1'b1, e_mem(3'd0, 1'b0, 1'b0), "lw mem wait");
        cyc(c_lw, 1'b0, 1'b1, 1'b1, e_mem(3'd0, 1'b0, 1'b0), "lw mem ready");
        cyc(c_lw, 1'b0, 1'b1, 1'b1, e_wb(3'd0, 2'd1, 2'd0), "lw wb");

        // Branch taken then not taken
        cyc(c_beq, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "beq t fetch");
        cyc(c_beq, 1'b0, 1'b1, 1'b1, e_dec(3'd2), "beq t decode");
        cyc(c_beq, 1'b1, 1'b1, 1'b1, e_br(2'd2), "beq t exec");
        cyc(c_beq, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "beq nt fetch");
        cyc(c_beq, 1'b0, 1'b1, 1'b1, e_dec(3'd2), "beq nt decode");
        cyc(c_beq, 1'b0, 1'b1, 1'b1, e_br(2'd0), "beq nt exec");

        // Store completing normally
        cyc(c_sw, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "sw fetch");
        cyc(c_sw, 1'b0, 1'b1, 1'b1, e_dec(3'd1), "sw decode");
        cyc(c_sw, 1'b0, 1'b1, 1'b1, e_exec(3'd1, 2'd0, 1'b1, 2'd0), "sw exec");
        cyc(c_sw, 1'b0, 1'b1, 1'b1, e_mem(3'd1, 1'b1, 1'b1), "sw mem");

        // Store interrupted by reset in MEM
        cyc(c_sw, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "sw2 fetch");
        cyc(c_sw, 1'b0, 1'b1, 1'b1, e_dec(3'd1), "sw2 decode");
        cyc(c_sw, 1'b0, 1'b1, 1'b1, e_exec(3'd1, 2'd0, 1'b1, 2'd0), "sw2 exec");
        cyc(c_sw, 1'b0, 1'b1, 1'b0, '0, "sw2 reset in mem");
        cyc(c_sw, 1'b0, 1'b0, 1'b1, e_fetch(1'b0), "fetch after sw reset");

        // Illegal opcode traps and stays trapped
        cyc(c_ill, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "ill fetch");
        cyc(c_ill, 1'b0, 1'b1, 1'b1, e_dec(3'd0), "ill decode");
        for (int i = 0; i < 20; i++)
            cyc(c_ill, 1'b1, 1'b1, 1'b1, e_trap(2'd1), "ill trap held");
        cyc(c_ill, 1'b0, 1'b1, 1'b0, '0, "trap reset");
        cyc(c_add, 1'b0, 1'b0, 1'b1, e_fetch(1'b0), "fetch after trap");

        // Bus timeout: 16 stalled fetch cycles then trap
        cyc(c_add, 1'b0, 1'b0, 1'b0, '0, "pre-timeout reset");
        for (int i = 0; i < 16; i++)
            cyc(c_add, 1'b0, 1'b0, 1'b1, e_fetch(1'b0), "timeout stall");
        cyc(c_add, 1'b0, 1'b1, 1'b1, e_trap(2'd2), "timeout trap");
        cyc(c_add, 1'b0, 1'b1, 1'b1, e_trap(2'd2), "timeout trap held");

        // Ready on the 16th cycle wins over the timeout
        cyc(c_add, 1'b0, 1'b0, 1'b0, '0, "pre-race reset");
        for (int i = 0; i < 15; i++)
            cyc(c_add, 1'b0, 1'b0, 1'b1, e_fetch(1'b0), "race stall");
        cyc(c_add, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "race ready on last");
        cyc(c_add, 1'b0, 1'b1, 1'b1, e_dec(3'd0), "race decode");
        cyc(c_add, 1'b0, 1'b1, 1'b1, e_exec(3'd0, 2'd0, 1'b0, 2'd2), "race exec");
        cyc(c_add, 1'b0, 1'b1, 1'b1, e_wb(3'd0, 2'd0, 2'd0), "race wb");
        cyc(c_add, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "race back to fetch");

        repeat (2) @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
